wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter: the parametrised successor of the team's single-grant round-robin prioritizer.
- Adds a per-requester weight, a grant/ack handshake, and a lock input for bursts.
- Used wherever N warps or units contend for one resource that may take several cycles to accept, e.g. the issue port or the scoreboard write port.
- Grant is combinational from the current request and the registered arbitration state. State advances only on an acknowledged grant.

---
 rtl/wrr_arbiter.sv | 83 ++++++++
 tb/tb_wrr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with grant/ack handshake and burst lock.
// Grant is combinational from req and the registered owner/credit state.
module wrr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int WEIGHT_W = 4,
   parameter int IDX_W    = $clog2(WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          req,
   input  logic [WIDTH*WEIGHT_W-1:0] weight,
   input  logic                      lock,
   input  logic                      ack,
   output logic [WIDTH-1:0]          grt,
   output logic [IDX_W-1:0]          grt_idx,
   output logic                      grt_valid
);

   logic [IDX_W-1:0]    r_own;
   logic [WEIGHT_W-1:0] r_cnt;
   logic                r_held;

   logic                w_valid;
   logic                w_sticky;
   logic                w_rot_found;
   logic [IDX_W-1:0]    w_rot_idx;
   logic [IDX_W-1:0]    w_idx;
   logic [WEIGHT_W-1:0] w_wfield;

   assign w_valid  = |req;
   assign w_sticky = r_held && req[r_own] && (lock || (r_cnt != '0));

   // Circular scan from r_own+1 through r_own; r_own has lowest priority.
   always_comb begin
      int unsigned pos;
      w_rot_found = 1'b0;
      w_rot_idx   = '0;
      pos         = 0;
      for (int unsigned k = 1; k <= WIDTH; k++) begin
         pos = (32'(r_own) + k) % WIDTH;
         if (!w_rot_found && req[pos]) begin
            w_rot_found = 1'b1;
            w_rot_idx   = IDX_W'(pos);
         end
      end
   end

   always_comb begin
      w_idx = '0;
      if (w_sticky)
         w_idx = r_own;
      else if (w_rot_found)
         w_idx = w_rot_idx;
   end

   assign w_wfield  = weight[32'(w_idx)*WEIGHT_W +: WEIGHT_W];
   assign grt_valid = w_valid;
   assign grt_idx   = w_idx;
   assign grt       = w_valid ? (WIDTH'(1) << w_idx) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_own  <= IDX_W'(WIDTH-1);
         r_cnt  <= '0;
         r_held <= 1'b0;
      end else if (ack && w_valid) begin
         if (w_sticky) begin
            // Under lock the credit is frozen; otherwise spend one and
            // release the turn when the last one is used.
            if (!lock) begin
               r_cnt <= r_cnt - WEIGHT_W'(1);
               if (r_cnt == WEIGHT_W'(1))
                  r_held <= 1'b0;
            end
         end else begin
            r_own  <= w_idx;
            r_cnt  <= w_wfield;
            r_held <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural turn/credit model.
module tb_wrr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  req = '0;
   logic [31:0] weight = '0;
   logic        lock = 1'b0;
   logic        ack = 1'b0;
   logic [7:0]  grt;
   logic [2:0]  grt_idx;
   logic        grt_valid;

   int total = 0;
   int bad   = 0;

   int wt[8];
   int m_own;
   int m_cnt;
   bit m_held;

   wrr_arbiter #(.WIDTH(8), .WEIGHT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .weight(weight), .lock(lock),
      .ack(ack), .grt(grt), .grt_idx(grt_idx), .grt_valid(grt_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (time=%0t required=<2ms)", $time);
      $fatal(1);
   end

   task automatic set_weights();
      for (int i = 0; i < 8; i++) weight[i*4 +: 4] = 4'(wt[i]);
   endtask

   task automatic clear_weights();
      for (int i = 0; i < 8; i++) wt[i] = 0;
      set_weights();
   endtask

   // Drive one cycle's inputs mid-low-phase and let combinational outputs settle.
   task automatic drive(input logic [7:0] r, input logic l, input logic a);
      @(negedge clk);
      req = r; lock = l; ack = a;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; lock = 1'b0; ack = 1'b0;
      m_own = 7; m_cnt = 0; m_held = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int m_pick(input logic [7:0] r, input logic l);
      if (m_held && r[m_own] && (l || m_cnt != 0)) return m_own;
      for (int k = 1; k <= 8; k++)
         if (r[(m_own + k) % 8]) return (m_own + k) % 8;
      return -1;
   endfunction

   task automatic test_reset();
      clear_weights();
      apply_reset();
      @(negedge clk); #1;
      total++;
      if (grt !== 8'h00) begin bad++; $display("FAIL reset_grt: got=%h exp=00", grt); end
      total++;
      if (grt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got=%0d exp=0", grt_idx); end
      total++;
      if (grt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b exp=0", grt_valid); end
      for (int i = 0; i < 9; i++) begin
         logic [2:0] e;
         logic [7:0] eg;
         e = 3'(i % 8);
         eg = 8'h01 << e;
         drive(8'hFF, 1'b0, 1'b1);
         total++;
         if (grt_idx !== e || grt !== eg || grt_valid !== 1'b1) begin
            bad++; $display("FAIL rr_seq[%0d]: got idx=%0d grt=%h exp idx=%0d grt=%h", i, grt_idx, grt, e, eg);
         end
      end
   endtask

   task automatic test_weight();
      int exp_seq[10] = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2};
      clear_weights();
      wt[2] = 3; set_weights();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive(8'h05, 1'b0, 1'b1);
         total++;
         if (grt_idx !== 3'(exp_seq[i])) begin
            bad++; $display("FAIL weight_seq[%0d]: got=%0d exp=%0d", i, grt_idx, exp_seq[i]);
         end
      end
   endtask

   task automatic test_no_ack();
      clear_weights();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive(8'h0A, 1'b0, 1'b0);
         total++;
         if (grt !== 8'h02) begin bad++; $display("FAIL noack_hold[%0d]: got=%h exp=02", i, grt); end
      end
      drive(8'h0A, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h02) begin bad++; $display("FAIL noack_acked: got=%h exp=02", grt); end
      drive(8'h0A, 1'b0, 1'b0);
      total++;
      if (grt !== 8'h08) begin bad++; $display("FAIL noack_next: got=%h exp=08", grt); end
   endtask

   task automatic test_lock();
      clear_weights();
      wt[1] = 1; set_weights();
      apply_reset();
      drive(8'h02, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h02) begin bad++; $display("FAIL lock_setup: got=%h exp=02", grt); end
      for (int i = 0; i < 6; i++) begin
         drive(8'h03, 1'b1, 1'b1);
         total++;
         if (grt !== 8'h02) begin bad++; $display("FAIL lock_hold[%0d]: got=%h exp=02", i, grt); end
      end
      drive(8'h03, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h02) begin bad++; $display("FAIL lock_last_credit: got=%h exp=02", grt); end
      drive(8'h03, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h01) begin bad++; $display("FAIL lock_rotate: got=%h exp=01", grt); end
   endtask

   task automatic test_owner_drop();
      clear_weights();
      wt[3] = 2; wt[4] = 1; set_weights();
      apply_reset();
      drive(8'h08, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h08) begin bad++; $display("FAIL drop_setup: got=%h exp=08", grt); end
      drive(8'h18, 1'b0, 1'b0);
      total++;
      if (grt !== 8'h08) begin bad++; $display("FAIL drop_sticky: got=%h exp=08", grt); end
      drive(8'h10, 1'b0, 1'b0);
      total++;
      if (grt !== 8'h10 || grt_idx !== 3'd4) begin bad++; $display("FAIL drop_same_cycle: got=%h idx=%0d exp=10 idx=4", grt, grt_idx); end
      drive(8'h10, 1'b0, 1'b1);
      drive(8'h18, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h10) begin bad++; $display("FAIL drop_new_credit: got=%h exp=10", grt); end
      drive(8'h18, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h08) begin bad++; $display("FAIL drop_credit_spent: got=%h exp=08", grt); end
   endtask

   task automatic test_mid_reset();
      clear_weights();
      wt[5] = 3; set_weights();
      apply_reset();
      drive(8'h20, 1'b0, 1'b1);
      drive(8'h21, 1'b0, 1'b0);
      total++;
      if (grt !== 8'h20) begin bad++; $display("FAIL midrst_before: got=%h exp=20", grt); end
      @(negedge clk);
      rst = 1'b1; #1;
      total++;
      if (grt !== 8'h01) begin bad++; $display("FAIL midrst_during: got=%h exp=01", grt); end
      @(negedge clk);
      rst = 1'b0; #1;
      total++;
      if (grt !== 8'h01) begin bad++; $display("FAIL midrst_after: got=%h exp=01", grt); end
      drive(8'h21, 1'b0, 1'b1);
      drive(8'h21, 1'b0, 1'b1);
      total++;
      if (grt !== 8'h20) begin bad++; $display("FAIL midrst_owner0: got=%h exp=20", grt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) wt[i] = $urandom_range(0, 3);
      set_weights();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         logic [7:0] r;
         logic l, a;
         int g;
         bit sticky;
         if (c % 50 == 49) begin
            wt[$urandom_range(0, 7)] = $urandom_range(0, 3);
            set_weights();
         end
         r = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         l = ($urandom_range(0, 4) == 0);
         a = ($urandom_range(0, 3) != 0);
         drive(r, l, a);
         g = m_pick(r, l);
         total++;
         if (g < 0) begin
            if (grt !== 8'h00 || grt_idx !== 3'd0 || grt_valid !== 1'b0) begin
               bad++; $display("FAIL rand_idle[%0d]: got grt=%h idx=%0d v=%b exp grt=00 idx=0 v=0", c, grt, grt_idx, grt_valid);
            end
         end else begin
            if (grt !== (8'h01 << g) || grt_idx !== 3'(g) || grt_valid !== 1'b1) begin
               bad++; $display("FAIL rand_grant[%0d]: got grt=%h idx=%0d v=%b exp idx=%0d v=1 (req=%h lock=%b)", c, grt, grt_idx, grt_valid, g, r, l);
            end
            if (a) begin
               sticky = m_held && r[m_own] && (l || m_cnt != 0);
               if (sticky) begin
                  if (!l) begin
                     m_cnt--;
                     if (m_cnt == 0) m_held = 0;
                  end
               end else begin
                  m_own = g; m_cnt = wt[g]; m_held = 1;
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_weight();
      test_no_ack();
      test_lock();
      test_owner_drop();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
